multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
- Sequencing controller for a multi-cycle build of the RV32 processor. It replaces the single-cycle opcode decoder.
- Walks each instruction through INIT/FETCH/DECODE/EXEC/MEM/WB and drives the datapath strobes (mem2reg, mem_write, mem_read, alu_src, reg_write, ALUOp) plus pc_write/ir_write.
- Holds data-memory strobes until mem_ready is seen, with a timeout to a sticky TRAP.
- The ALU controller still consumes alu_op with funct3/funct7.

Parameters:
- MEM_TIMEOUT, 16: maximum consecutive MEM cycles without mem_ready before TRAP; legal range 1..255.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- opcode  in  7  instruction opcode from datapath IR output
- mem_ready  in  1  data-memory completion, sampled in MEM
- pc_write  out  1  PC <= PC+4 strobe
- ir_write  out  1  instruction register load strobe
- mem_read  out  1  data-memory read request
- mem_write  out  1  data-memory write request
- mem2reg  out  1  writeback mux: 1 = memory data, 0 = ALU result
- alu_src  out  1  ALU B operand: 1 = immediate, 0 = rs2
- reg_write  out  1  register file write enable
- alu_op  out  2  00 = add (address), 10 = R-type, 11 = I-type ALU
- state  out  3  current state, for debug/verification
- trap  out  1  sticky fault flag
- trap_cause  out  2  00 = none, 01 = illegal opcode, 10 = memory timeout

Behaviour:
- State encoding: INIT=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, TRAP=6.
- All outputs are Moore: decoded from the state register and opc_q (opcode latched in DECODE).
- Reset, asynchronous: state=INIT, opc_q=0, timeout counter=0, trap_cause=00. Every strobe and alu_op is 0 while reset is asserted and in INIT.
- INIT: no strobes; next state FETCH (one cycle).
- FETCH: ir_write=1, pc_write=1, alu_op=00; next state DECODE.
- DECODE: opc_q <= opcode; no strobes.
  - Supported opcodes: 0110011 (R), 0010011 (I-ALU), 0000011 (LOAD), 0100011 (STORE).
  - Any other opcode -> TRAP with trap_cause=01. Otherwise next state EXEC.
- EXEC: alu_src=0 for R, 1 otherwise; alu_op=10 for R, 11 for I-ALU, 00 for LOAD/STORE.
  - LOAD/STORE -> MEM; R/I-ALU -> WB.
- MEM: alu_src=1, alu_op=00.
  - mem_read=1 for LOAD, mem_write=1 for STORE, held every MEM cycle.
  - Timeout counter clears on MEM entry and increments on each MEM cycle where mem_ready=0.
  - mem_ready=1 -> STORE goes to FETCH; LOAD goes to WB.
  - mem_ready=0 with counter==MEM_TIMEOUT-1 -> TRAP with trap_cause=10. MEM therefore lasts at most MEM_TIMEOUT cycles.
  - mem_ready=1 in the final allowed cycle wins over the timeout.
- WB: reg_write=1 for exactly one cycle; mem2reg=1 for LOAD; alu_src/alu_op hold their EXEC values; next state FETCH.
- TRAP: all strobes 0, trap=1, trap_cause held; only reset exits.
- Cycle cost per instruction, FETCH to next FETCH: R/I = 4 cycles; STORE = 3+n; LOAD = 4+n (n = MEM cycles, n ≥ 1).
- Reset asserted mid-operation (any state, including mid-MEM): strobes drop in the same cycle, with no clock edge needed. After deassertion the sequence restarts at INIT.
- The opcode input is ignored outside DECODE.

Optional Feature:
- Macro: MULTICYCLE_PERF_CNT_EN.
- When defined, adds two outputs, both reset to 0, wrap-around at 2^32, frozen in TRAP:
  - cycle_count[31:0]: increments every cycle except in INIT.
  - instr_retired[31:0]: increments on the WB->FETCH transition and on a completing STORE MEM->FETCH transition.
- When undefined, neither port nor its counter logic exists.

Test Plan:
- R-type (opcode 0110011): after reset deassertion, states INIT,FETCH,DECODE,EXEC,WB,FETCH. reg_write=1 only in WB; alu_op=10 and alu_src=0 in EXEC and WB.
- LOAD (0000011), mem_ready high on 3rd MEM cycle: mem_read high for exactly 3 cycles. WB has reg_write=1 and mem2reg=1; FETCH-to-FETCH = 7 cycles.
- STORE (0100011), mem_ready high on first MEM cycle: mem_write pulses 1 cycle; reg_write never asserts; back to FETCH after 4 cycles.
- Opcode 1100011 (branch, unsupported): TRAP entered the cycle after DECODE with trap=1 and trap_cause=01. trap remains set for 20+ cycles despite any opcode/mem_ready activity.
- mem_ready held 0 for LOAD, MEM_TIMEOUT=16: mem_read high exactly 16 cycles, then TRAP with trap_cause=10. A variant with mem_ready=1 on the 16th cycle completes to WB without trapping.
- Assert reset on the 2nd MEM cycle of a STORE: mem_write falls before the next clock edge and state=INIT. After release, FETCH follows one cycle later and the counters read 0 (with MULTICYCLE_PERF_CNT_EN).

Source files
------------

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - RV32 multi-cycle sequencing controller (optional MULTICYCLE_PERF_CNT_EN perf counters)
module multicycle_controller #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  opcode,
    input  logic        mem_ready,
    output logic        pc_write,
    output logic        ir_write,
    output logic        mem_read,
    output logic        mem_write,
    output logic        mem2reg,
    output logic        alu_src,
    output logic        reg_write,
    output logic [1:0]  alu_op,
    output logic [2:0]  state,
    output logic        trap,
    output logic [1:0]  trap_cause
`ifdef MULTICYCLE_PERF_CNT_EN
    ,
    output logic [31:0] cycle_count,
    output logic [31:0] instr_retired
`endif
);

    typedef enum logic [2:0] {
        S_INIT   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_TRAP   = 3'd6
    } state_t;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t      cur;
    state_t      nxt;
    logic [6:0]  opc_q;
    logic [6:0]  opc_n;
    logic [7:0]  tcnt;
    logic [7:0]  tcnt_n;
    logic [1:0]  cause_n;

    assign state = cur;

    // Next-state, opcode latch, MEM timeout counter and trap cause selection
    always_comb begin
        nxt     = cur;
        opc_n   = opc_q;
        tcnt_n  = tcnt;
        cause_n = trap_cause;
        case (cur)
            S_INIT:   nxt = S_FETCH;
            S_FETCH:  nxt = S_DECODE;
            S_DECODE: begin
                opc_n = opcode;
                if (opcode == OP_R || opcode == OP_I ||
                    opcode == OP_LOAD || opcode == OP_STORE) begin
                    nxt = S_EXEC;
                end else begin
                    nxt     = S_TRAP;
                    cause_n = 2'b01;
                end
            end
            S_EXEC: begin
                if (opc_q == OP_LOAD || opc_q == OP_STORE) begin
                    nxt    = S_MEM;
                    tcnt_n = 8'd0;
                end else begin
                    nxt = S_WB;
                end
            end
            S_MEM: begin
                // A late mem_ready on the final allowed cycle still completes the access
                if (mem_ready) begin
                    nxt = (opc_q == OP_STORE) ? S_FETCH : S_WB;
                end else if (tcnt == TIMEOUT_LAST) begin
                    nxt     = S_TRAP;
                    cause_n = 2'b10;
                end else begin
                    tcnt_n = tcnt + 8'd1;
                end
            end
            S_WB:     nxt = S_FETCH;
            S_TRAP:   nxt = S_TRAP;
            default:  nxt = S_INIT;
        endcase
    end

    // State register plus strobes registered from the state being entered
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur        <= S_INIT;
            opc_q      <= 7'd0;
            tcnt       <= 8'd0;
            trap_cause <= 2'b00;
            pc_write   <= 1'b0;
            ir_write   <= 1'b0;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            mem2reg    <= 1'b0;
            alu_src    <= 1'b0;
            reg_write  <= 1'b0;
            alu_op     <= 2'b00;
            trap       <= 1'b0;
        end else begin
            cur        <= nxt;
            opc_q      <= opc_n;
            tcnt       <= tcnt_n;
            trap_cause <= cause_n;
            pc_write   <= 1'b0;
            ir_write   <= 1'b0;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            mem2reg    <= 1'b0;
            alu_src    <= 1'b0;
            reg_write  <= 1'b0;
            alu_op     <= 2'b00;
            trap       <= 1'b0;
            case (nxt)
                S_FETCH: begin
                    pc_write <= 1'b1;
                    ir_write <= 1'b1;
                end
                S_EXEC, S_WB: begin
                    alu_src <= (opc_n != OP_R);
                    if (opc_n == OP_R)      alu_op <= 2'b10;
                    else if (opc_n == OP_I) alu_op <= 2'b11;
                    else                    alu_op <= 2'b00;
                    if (nxt == S_WB) begin
                        reg_write <= 1'b1;
                        mem2reg   <= (opc_n == OP_LOAD);
                    end
                end
                S_MEM: begin
                    alu_src   <= 1'b1;
                    mem_read  <= (opc_n == OP_LOAD);
                    mem_write <= (opc_n == OP_STORE);
                end
                S_TRAP:  trap <= 1'b1;
                default: ;
            endcase
        end
    end

`ifdef MULTICYCLE_PERF_CNT_EN
    // Cycle and retired-instruction counters, idle in INIT and frozen in TRAP
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_count   <= 32'd0;
            instr_retired <= 32'd0;
        end else begin
            if (cur != S_INIT && cur != S_TRAP) begin
                cycle_count <= cycle_count + 32'd1;
            end
            if ((cur == S_WB || cur == S_MEM) && nxt == S_FETCH) begin
                instr_retired <= instr_retired + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - randomized self-checking bench for multicycle_controller
module tb_multicycle_controller;

    localparam int TO = 16;
    localparam int K_NONE = 0, K_R = 1, K_I = 2, K_LD = 3, K_ST = 4;
    localparam logic [2:0] S_INIT = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2,
                           S_EXEC = 3'd3, S_MEM = 3'd4, S_WB = 3'd5, S_TRAP = 3'd6;
    localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011,
                           OP_LD = 7'b0000011, OP_ST = 7'b0100011;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [6:0]  opcode = 7'd0;
    logic        mem_ready = 1'b0;
    logic        pc_write, ir_write, mem_read, mem_write, mem2reg, alu_src, reg_write, trap;
    logic [1:0]  alu_op, trap_cause;
    logic [2:0]  state;

    int          vectors = 0;
    int          miscompares = 0;
    logic [1:0]  exp_cause = 2'b00;
    logic [2:0]  prev_st = S_INIT;
    bit          trapped;

`ifdef MULTICYCLE_PERF_CNT_EN
    logic [31:0] cycle_count, instr_retired;
    logic [31:0] m_cyc = 32'd0;
    logic [31:0] m_ret = 32'd0;
`endif

    multicycle_controller #(.MEM_TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .ir_write(ir_write), .mem_read(mem_read),
        .mem_write(mem_write), .mem2reg(mem2reg), .alu_src(alu_src),
        .reg_write(reg_write), .alu_op(alu_op), .state(state),
        .trap(trap), .trap_cause(trap_cause)
`ifdef MULTICYCLE_PERF_CNT_EN
        , .cycle_count(cycle_count), .instr_retired(instr_retired)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: observed no finish, expected finish before 1ms");
        $fatal(1, "watchdog");
    end

    function automatic int classify(input logic [6:0] opc);
        case (opc)
            OP_R:    return K_R;
            OP_I:    return K_I;
            OP_LD:   return K_LD;
            OP_ST:   return K_ST;
            default: return K_NONE;
        endcase
    endfunction

    // Expected {state, pc_write, ir_write, mem_read, mem_write, mem2reg, alu_src, reg_write, alu_op, trap, trap_cause}
    function automatic logic [14:0] model_out(input logic [2:0] st, input int kind, input logic [1:0] cause);
        logic pcw, irw, mrd, mwr, m2r, asrc, rw;
        logic [1:0] aop;
        pcw = 0; irw = 0; mrd = 0; mwr = 0; m2r = 0; asrc = 0; rw = 0; aop = 2'b00;
        if (st == S_FETCH) begin
            pcw = 1; irw = 1;
        end
        if (st == S_EXEC || st == S_WB) begin
            asrc = (kind != K_R);
            aop  = (kind == K_R) ? 2'b10 : (kind == K_I) ? 2'b11 : 2'b00;
        end
        if (st == S_WB) begin
            rw = 1; m2r = (kind == K_LD);
        end
        if (st == S_MEM) begin
            asrc = 1; mrd = (kind == K_LD); mwr = (kind == K_ST);
        end
        return {st, pcw, irw, mrd, mwr, m2r, asrc, rw, aop, (st == S_TRAP), cause};
    endfunction

    task automatic check(input string tag, input logic [2:0] st, input int kind);
        logic [14:0] exp_v, got_v;
        exp_v = model_out(st, kind, exp_cause);
        got_v = {state, pc_write, ir_write, mem_read, mem_write, mem2reg, alu_src,
                 reg_write, alu_op, trap, trap_cause};
        vectors++;
        assert (got_v === exp_v) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, got_v, exp_v);
        end
`ifdef MULTICYCLE_PERF_CNT_EN
        vectors++;
        assert ({cycle_count, instr_retired} === {m_cyc, m_ret}) else begin
            miscompares++;
            $error("FAIL %s_perf: observed %0d/%0d expected %0d/%0d",
                   tag, cycle_count, instr_retired, m_cyc, m_ret);
        end
`endif
        prev_st = st;
    endtask

    task automatic step(input string tag, input logic [2:0] st, input int kind);
        @(negedge clk);
`ifdef MULTICYCLE_PERF_CNT_EN
        if (prev_st != S_INIT && prev_st != S_TRAP) m_cyc++;
        if ((prev_st == S_WB || prev_st == S_MEM) && st == S_FETCH) m_ret++;
`endif
        check(tag, st, kind);
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        exp_cause = 2'b00;
`ifdef MULTICYCLE_PERF_CNT_EN
        m_cyc = 32'd0;
        m_ret = 32'd0;
`endif
        #1;
        check({tag, "_asserted"}, S_INIT, K_NONE);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check({tag, "_released"}, S_INIT, K_NONE);
    endtask

    // ready_at: MEM cycle (1-based) that sees mem_ready, 0 = never; rst_at: MEM cycle after which reset hits
    task automatic run_instr(input logic [6:0] opc, input int ready_at, input int rst_at, output bit trp);
        int  kind;
        bit  done;
        kind = classify(opc);
        trp = 0;
        step("fetch", S_FETCH, kind);
        opcode = 7'($urandom);
        mem_ready = 1'($urandom);
        step("decode", S_DECODE, kind);
        opcode = opc;
        if (kind == K_NONE) begin
            exp_cause = 2'b01;
            step("illegal_trap", S_TRAP, kind);
            for (int i = 0; i < 22; i++) begin
                opcode = 7'($urandom);
                mem_ready = 1'($urandom);
                step("illegal_hold", S_TRAP, kind);
            end
            trp = 1;
            return;
        end
        step("exec", S_EXEC, kind);
        opcode = 7'($urandom);
        mem_ready = 1'($urandom);
        if (kind == K_LD || kind == K_ST) begin
            done = 0;
            for (int k = 1; k <= TO && !done; k++) begin
                step("mem", S_MEM, kind);
                if (k == rst_at) begin
                    do_reset("reset_mid_mem");
                    trp = 1;
                    return;
                end
                mem_ready = (k == ready_at);
                done = (k == ready_at);
            end
            if (!done) begin
                exp_cause = 2'b10;
                step("timeout_trap", S_TRAP, kind);
                for (int i = 0; i < 3; i++) begin
                    mem_ready = 1'($urandom);
                    opcode = 7'($urandom);
                    step("timeout_hold", S_TRAP, kind);
                end
                trp = 1;
                return;
            end
            if (kind == K_ST) return;
        end
        step("wb", S_WB, kind);
        mem_ready = 1'($urandom);
    endtask

    initial begin
        logic [6:0] bad_ops [4];
        int r;
        bad_ops[0] = 7'b1100011;
        bad_ops[1] = 7'b1101111;
        bad_ops[2] = 7'b0110111;
        bad_ops[3] = 7'b0000000;

        repeat (2) @(negedge clk);
        do_reset("por");

        run_instr(OP_R, 0, 0, trapped);
        run_instr(OP_LD, 3, 0, trapped);
        run_instr(OP_ST, 1, 0, trapped);
        run_instr(OP_I, 0, 0, trapped);
        run_instr(OP_LD, TO, 0, trapped);
        run_instr(OP_LD, 0, 0, trapped);
        if (trapped) do_reset("after_timeout");
        run_instr(7'b1100011, 0, 0, trapped);
        if (trapped) do_reset("after_illegal");
        run_instr(OP_ST, 0, 2, trapped);

        repeat (60) begin
            r = $urandom_range(0, 19);
            if (r <= 4)       run_instr(OP_R, 0, 0, trapped);
            else if (r <= 8)  run_instr(OP_I, 0, 0, trapped);
            else if (r <= 13) run_instr(OP_LD, $urandom_range(1, 6), 0, trapped);
            else if (r <= 17) run_instr(OP_ST, $urandom_range(1, 6), 0, trapped);
            else if (r == 18) run_instr(bad_ops[$urandom_range(0, 3)], 0, 0, trapped);
            else              run_instr(($urandom_range(0, 1) == 1) ? OP_LD : OP_ST, 0, 0, trapped);
            if (trapped) do_reset("recover");
        end
        step("final_fetch", S_FETCH, K_NONE);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
